// File: rtl/cpu_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/memory side (slave).
// The sequencer drives all strobes, status and the retired-instruction count.
interface cpu_sequencer_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             run;
    logic [3:0]       opcode;
    logic             zero_flag;
    logic             mem_ready;

    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             ir_load;
    logic             pc_inc;
    logic             pc_load;
    logic             alu_en;
    logic             rf_we;
    logic             wb_sel_mem;
    logic             halted;
    logic             mem_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, opcode, zero_flag, mem_ready,
        output imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, alu_en, rf_we,
               wb_sel_mem, halted, mem_err, state, instr_count
    );

    modport slave (
        output run, opcode, zero_flag, mem_ready,
        input  imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, alu_en, rf_we,
               wb_sel_mem, halted, mem_err, state, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 4-bit-opcode core, with a
// req/ready memory handshake guarded by a timeout that traps into a sticky ERR state.
module cpu_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input logic             clk,
    input logic             rst_n,
    cpu_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6,
        StErr    = 3'd7
    } state_e;

    localparam int unsigned TmoW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit TmoEn = (MEM_TIMEOUT != 0);

    state_e           state_q;
    logic [3:0]       op_q;
    logic [TmoW-1:0]  tmo_q;
    logic [CNT_W-1:0] count_q;
    logic             mem_err_q;

    logic is_rtype, is_bne, is_load, is_store, tmo_expired;

    always_comb begin
        is_rtype    = (op_q < 4'd5);
        is_bne      = (op_q == 4'd5);
        is_load     = (op_q == 4'd6);
        is_store    = (op_q == 4'd7);
        // The wait cycle that would be the MEM_TIMEOUT-th without mem_ready.
        tmo_expired = TmoEn && (tmo_q == TmoLast);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= 4'd0;
            tmo_q     <= '0;
            count_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            // Counter is zero on every entry to FETCH/MEM; only a stalled wait advances it.
            tmo_q <= '0;
            case (state_q)
                StIdle: begin
                    if (bus.run) state_q <= StFetch;
                end
                StFetch: begin
                    if (bus.mem_ready) begin
                        state_q <= StDecode;
                    end else if (tmo_expired) begin
                        state_q   <= StErr;
                        mem_err_q <= 1'b1;
                    end else if (TmoEn) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StDecode: begin
                    op_q <= bus.opcode;
                    if (bus.opcode == 4'hF) begin
                        state_q <= StHalt;
                        count_q <= count_q + 1'b1;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (is_rtype) begin
                        state_q <= StWb;
                    end else if (is_load || is_store) begin
                        state_q <= StMem;
                    end else begin
                        count_q <= count_q + 1'b1;
                        state_q <= bus.run ? StFetch : StIdle;
                    end
                end
                StMem: begin
                    if (bus.mem_ready) begin
                        if (is_load) begin
                            state_q <= StWb;
                        end else begin
                            count_q <= count_q + 1'b1;
                            state_q <= bus.run ? StFetch : StIdle;
                        end
                    end else if (tmo_expired) begin
                        state_q   <= StErr;
                        mem_err_q <= 1'b1;
                    end else if (TmoEn) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                StWb: begin
                    count_q <= count_q + 1'b1;
                    state_q <= bus.run ? StFetch : StIdle;
                end
                default: ;  // HALT and ERR are left only through reset
            endcase
        end
    end

    always_comb begin
        bus.imem_req    = (state_q == StFetch);
        bus.ir_load     = (state_q == StFetch) && bus.mem_ready;
        bus.pc_inc      = (state_q == StFetch) && bus.mem_ready;
        bus.alu_en      = (state_q == StExec);
        bus.pc_load     = (state_q == StExec) && is_bne && !bus.zero_flag;
        bus.dmem_req    = (state_q == StMem);
        bus.dmem_we     = (state_q == StMem) && is_store;
        bus.rf_we       = (state_q == StWb);
        bus.wb_sel_mem  = (state_q == StWb) && is_load;
        bus.halted      = (state_q == StHalt);
        bus.mem_err     = mem_err_q;
        bus.state       = state_q;
        bus.instr_count = count_q;
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized self-checking bench for cpu_sequencer: each instruction is expanded by an
// instruction-level model into its expected per-cycle phase/strobe trace.
module tb_cpu_sequencer;
    localparam int TMO   = 15;
    localparam int CNT_W = 8;  // narrow so the random run crosses the counter wrap

    localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3;
    localparam int ST_MEM = 4, ST_WB = 5, ST_HALT = 6, ST_ERR = 7;

    // Strobe vector: {imem, dmem, we, ir_load, pc_inc, pc_load, alu, rf_we, wb_mem, halted, err}
    localparam logic [10:0] S_NONE = 11'd0;
    localparam logic [10:0] S_IMEM = 11'd1 << 10;
    localparam logic [10:0] S_DMEM = 11'd1 << 9;
    localparam logic [10:0] S_WE   = 11'd1 << 8;
    localparam logic [10:0] S_IRL  = 11'd1 << 7;
    localparam logic [10:0] S_PCI  = 11'd1 << 6;
    localparam logic [10:0] S_PCL  = 11'd1 << 5;
    localparam logic [10:0] S_ALU  = 11'd1 << 4;
    localparam logic [10:0] S_RFWE = 11'd1 << 3;
    localparam logic [10:0] S_WBM  = 11'd1 << 2;
    localparam logic [10:0] S_HALT = 11'd1 << 1;
    localparam logic [10:0] S_ERR  = 11'd1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_count = 0;

    cpu_sequencer_if #(.CNT_W(CNT_W)) bus ();

    cpu_sequencer #(
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] observed();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_load, bus.pc_inc, bus.pc_load,
                bus.alu_en, bus.rf_we, bus.wb_sel_mem, bus.halted, bus.mem_err};
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    task automatic drive(input logic ready, input logic [3:0] op, input logic z, input logic run);
        bus.mem_ready = ready;
        bus.opcode    = op;
        bus.zero_flag = z;
        bus.run       = run;
    endtask

    task automatic bump();
        exp_count = (exp_count + 1) % (1 << CNT_W);
    endtask

    // Sample one cycle at the falling edge, then move to just after the next rising edge.
    task automatic step(input string tag, input int st, input logic [10:0] exp_s);
        @(negedge clk);
        check_eq({tag, " state"}, 32'(bus.state), 32'(st));
        check_eq({tag, " strobes"}, 32'(observed()), 32'(exp_s));
        check_eq({tag, " count"}, 32'(bus.instr_count), 32'(exp_count));
        @(posedge clk);
        #1;
    endtask

    task automatic leave_idle(input int k);
        for (int i = 0; i < k; i++) begin
            drive(rnd1(), 4'($urandom), rnd1(), 1'b0);
            step("idle", ST_IDLE, S_NONE);
        end
        drive(rnd1(), 4'($urandom), rnd1(), 1'b1);
        step("idle-go", ST_IDLE, S_NONE);
    endtask

    // One instruction from FETCH. wf/wm are stall cycles before mem_ready; >= TMO means
    // no ready arrives and the sequence stops at the point the model expects ERR.
    task automatic do_instr(input logic [3:0] op, input logic z, input int wf, input int wm,
                            input logic run_end);
        bit ld, st, bne, rt, retire_exec;
        int n;
        ld  = (op == 4'd6);
        st  = (op == 4'd7);
        bne = (op == 4'd5);
        rt  = (op < 4'd5);
        n = (wf >= TMO) ? TMO : wf + 1;
        for (int i = 0; i < n; i++) begin
            bit last;
            last = (wf < TMO) && (i == wf);
            drive(last, 4'($urandom), rnd1(), rnd1());
            step("fetch", ST_FETCH, S_IMEM | (last ? (S_IRL | S_PCI) : S_NONE));
        end
        if (wf >= TMO) return;
        drive(rnd1(), op, rnd1(), rnd1());
        step("decode", ST_DECODE, S_NONE);
        if (op == 4'hF) begin
            bump();
            return;
        end
        retire_exec = !(rt || ld || st);
        drive(rnd1(), 4'($urandom), z, retire_exec ? run_end : rnd1());
        step("exec", ST_EXEC, S_ALU | ((bne && !z) ? S_PCL : S_NONE));
        if (retire_exec) begin
            bump();
            return;
        end
        if (ld || st) begin
            n = (wm >= TMO) ? TMO : wm + 1;
            for (int i = 0; i < n; i++) begin
                bit last;
                last = (wm < TMO) && (i == wm);
                drive(last, 4'($urandom), rnd1(), (st && last) ? run_end : rnd1());
                step("mem", ST_MEM, S_DMEM | (st ? S_WE : S_NONE));
            end
            if (wm >= TMO) return;
            if (st) begin
                bump();
                return;
            end
        end
        drive(rnd1(), 4'($urandom), rnd1(), run_end);
        step("wb", ST_WB, S_RFWE | (ld ? S_WBM : S_NONE));
        bump();
    endtask

    task automatic err_hold(input int k);
        for (int i = 0; i < k; i++) begin
            drive(rnd1(), 4'($urandom), rnd1(), rnd1());
            step("err", ST_ERR, S_ERR);
        end
    endtask

    // Called just after a rising edge: reset must act before the next edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_eq({tag, " state"}, 32'(bus.state), 32'(ST_IDLE));
        check_eq({tag, " strobes"}, 32'(observed()), 32'(S_NONE));
        check_eq({tag, " count"}, 32'(bus.instr_count), 32'd0);
        exp_count = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        #12;
        check_eq("reset state", 32'(bus.state), 32'(ST_IDLE));
        check_eq("reset strobes", 32'(observed()), 32'(S_NONE));
        check_eq("reset count", 32'(bus.instr_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        leave_idle(2);

        do_instr(4'd2, 1'b0, 0, 0, 1'b1);
        do_instr(4'd5, 1'b0, 0, 0, 1'b1);
        do_instr(4'd5, 1'b1, 0, 0, 1'b1);
        do_instr(4'd6, 1'b0, 0, 3, 1'b1);
        do_instr(4'd7, 1'b0, 0, 0, 1'b1);
        do_instr(4'd6, 1'b0, TMO - 1, TMO - 1, 1'b1);
        do_instr(4'd6, 1'b0, 1, 2, 1'b0);
        leave_idle(1);

        for (int k = 0; k < 400; k++) begin
            logic [3:0] op;
            int         wf, wm;
            logic       re;
            op = 4'($urandom_range(14, 0));
            wf = ($urandom_range(3, 0) == 0) ? int'($urandom_range(TMO - 1, 1)) : 0;
            wm = ($urandom_range(3, 0) == 0) ? int'($urandom_range(TMO - 1, 1)) : 0;
            re = ($urandom_range(7, 0) != 0);
            do_instr(op, rnd1(), wf, wm, re);
            if (!re) leave_idle(int'($urandom_range(2, 0)));
        end

        // Fetch never answered: trap into ERR after TMO stalled cycles.
        do_instr(4'd0, 1'b0, TMO, 0, 1'b1);
        err_hold(3);
        async_reset("err-fetch reset");

        leave_idle(0);
        do_instr(4'd7, 1'b0, 0, TMO, 1'b1);
        err_hold(3);
        async_reset("err-mem reset");

        leave_idle(0);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        check_eq("imem before reset", 32'(bus.imem_req), 32'd1);
        async_reset("mid-fetch reset");

        leave_idle(0);
        drive(1'b1, 4'd0, 1'b0, 1'b1);
        step("fetch", ST_FETCH, S_IMEM | S_IRL | S_PCI);
        drive(1'b0, 4'd6, 1'b0, 1'b1);
        step("decode", ST_DECODE, S_NONE);
        step("exec", ST_EXEC, S_ALU);
        check_eq("dmem before reset", 32'(bus.dmem_req), 32'd1);
        async_reset("mid-mem reset");

        leave_idle(0);
        do_instr(4'hF, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(rnd1(), 4'($urandom), rnd1(), 1'(i));
            step("halt", ST_HALT, S_HALT);
        end
        async_reset("halt reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
